// File: rtl/mb_serial_tx_ctrl_pkg.sv
// Shared types and default frame geometry for the serial CRC link
// (transmit sequencer, datapath and receiver).
package mb_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DATA,
    ST_CRC,
    ST_END
  } state_t;

  localparam int MB_DATA_W = 8;
  localparam int MB_CRC_W  = 4;
  localparam int MB_GAP    = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bit counter width; floored at 1 so an all-ones geometry still has a port.
  function automatic int cnt_width(input int data_w, input int crc_w, input int gap);
    int m;
    m = max3(data_w, crc_w, gap);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mb_serial_tx_ctrl_if.sv
// Control bundle between the frame requester and the transmit sequencer.
interface mb_serial_tx_ctrl_if
  import mb_serial_pkg::*;
#(
  parameter int CNT_W = cnt_width(MB_DATA_W, MB_CRC_W, MB_GAP)
);
  logic             Enable;
  logic             Abort;
  logic             Load;
  logic             ShiftEn;
  logic             CrcEn;
  logic             Select;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] BitCnt;

  modport master (
    output Enable, Abort,
    input  Load, ShiftEn, CrcEn, Select, Busy, Done, BitCnt
  );

  modport slave (
    input  Enable, Abort,
    output Load, ShiftEn, CrcEn, Select, Busy, Done, BitCnt
  );
endinterface

// File: rtl/mb_serial_tx_ctrl.sv
// Transmit sequencer: LOAD, DATA_W payload shifts, CRC_W checksum shifts,
// then GAP END cycles. All outputs are Moore-decoded from state and BitCnt.
//
//   state    | meaning
//   ST_IDLE  | waiting for Enable
//   ST_LOAD  | one-cycle parallel load of data reg, CRC reg cleared
//   ST_DATA  | shifting payload, CRC accumulating
//   ST_CRC   | shifting checksum out
//   ST_END   | inter-frame gap; Done on first cycle, Enable sampled on last
module mb_serial_tx_ctrl
  import mb_serial_pkg::*;
#(
  parameter int DATA_W = MB_DATA_W,
  parameter int CRC_W  = MB_CRC_W,
  parameter int GAP    = MB_GAP
) (
  input  logic                CLK,
  input  logic                CLR,
  mb_serial_tx_ctrl_if.slave  bus
);

  localparam int CNT_W = cnt_width(DATA_W, CRC_W, GAP);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DATA_LAST = cnt_t'(DATA_W - 1);
  localparam cnt_t CRC_LAST  = cnt_t'(CRC_W - 1);
  localparam cnt_t GAP_LAST  = cnt_t'(GAP - 1);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("mb_serial_tx_ctrl: DATA_W must be >= 1");
  end
  if (CRC_W < 1) begin : g_bad_crc_w
    $error("mb_serial_tx_ctrl: CRC_W must be >= 1");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("mb_serial_tx_ctrl: GAP must be >= 1");
  end

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.Enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = ST_CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_CRC: begin
        if (cnt_q == CRC_LAST) begin
          state_d = ST_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_END: begin
        if (cnt_q == GAP_LAST) begin
          state_d = bus.Enable ? ST_LOAD : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides every in-frame transition and suppresses Done.
    if (bus.Abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign bus.Load    = (state_q == ST_LOAD);
  assign bus.ShiftEn = (state_q == ST_DATA) || (state_q == ST_CRC);
  assign bus.CrcEn   = (state_q == ST_DATA);
  assign bus.Select  = (state_q == ST_CRC);
  assign bus.Busy    = (state_q != ST_IDLE);
  assign bus.Done    = (state_q == ST_END) && (cnt_q == '0);
  assign bus.BitCnt  = cnt_q;

endmodule

// File: doc/mb_serial_tx_ctrl.md
# mb_serial_tx_ctrl

Parametrised transmit sequencer for the serial CRC link. It replaces the two-flip-flop load/shift controller with a single-clock FSM and an internal bit counter. It drives the parallel-load strobe, the shift clock-enable and the data/CRC output-path select for a DATA_W-bit payload followed by a CRC_W-bit checksum. No gated clock is produced; every datapath register runs on CLK and qualifies on ShiftEn.

## Interface
Parameters:
- DATA_W, default 8: payload bits per frame; must be ≥1.
- CRC_W, default 4: CRC bits appended per frame; must be ≥1.
- GAP, default 1: END cycles between the last CRC bit and the next LOAD; must be ≥1.

Ports:
- CLK  in  1  single system clock; all state changes on its rising edge.
- CLR  in  1  reset, synchronous, active-high.
- Enable  in  1  frame request. Sampled in IDLE and in the last END cycle only.
- Abort  in  1  cancels the frame in progress.
- Load  out  1  one-cycle strobe: parallel-load the data shift register and clear the CRC register.
- ShiftEn  out  1  shift enable for the data and CRC shift registers.
- CrcEn  out  1  CRC accumulate enable; active during the DATA phase only.
- Select  out  1  serial-out mux: 0 = data register, 1 = CRC register.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when a frame completes.
- BitCnt  out  CNT_W  bit index within the current phase. CNT_W = $clog2(max(DATA_W,CRC_W,GAP)).

## Operation
- States: IDLE, LOAD, DATA, CRC, END. Outputs are Moore-decoded from the state register and BitCnt.
- IDLE: all outputs 0. If Enable=1, go to LOAD.
- LOAD (1 cycle): Load=1. Go to DATA with BitCnt=0.
- DATA: ShiftEn=1, CrcEn=1, Select=0. BitCnt increments each cycle. At BitCnt=DATA_W-1, go to CRC with BitCnt=0.
- CRC: ShiftEn=1, CrcEn=0, Select=1. At BitCnt=CRC_W-1, go to END with BitCnt=0.
- END (GAP cycles): Done=1 in the first END cycle only. Select=0 and ShiftEn=0.
- Leaving END: in the last END cycle (BitCnt=GAP-1), Enable=1 goes to LOAD (back-to-back frame); otherwise go to IDLE.
- Enable outside IDLE and the last END cycle is ignored. Requests are not queued.
- Abort=1 in LOAD, DATA, CRC or END: go to IDLE next cycle with BitCnt=0. No Done pulse. Abort in IDLE has no effect.
- Priority: CLR > Abort > normal transitions.
- BitCnt counts in modulo-free fashion. It never exceeds max(DATA_W,CRC_W,GAP)-1.

## Timing
- Reset: after a CLR=1 edge, state=IDLE, BitCnt=0, and Load, ShiftEn, CrcEn, Select, Busy, Done are all 0. CLR mid-frame behaves the same; no Done is issued.
- Enable high at edge k in IDLE:
  - Load=1 in cycle k+1.
  - DATA shifts in cycles k+2 … k+DATA_W+1.
  - CRC shifts in cycles k+DATA_W+2 … k+DATA_W+CRC_W+1.
  - Done=1 in cycle k+DATA_W+CRC_W+2.
- Frame length is 1+DATA_W+CRC_W+GAP cycles from Load to the next possible Load.
- Latency from Enable to Load is 1 cycle. The first serial bit is valid in the first DATA cycle.
- Exactly DATA_W ShiftEn cycles with Select=0 and CRC_W with Select=1 per completed frame.
- Continuous Enable=1 produces back-to-back frames with no IDLE cycle.

## Structure
- Package mb_serial_pkg holds:
  - the state typedef (IDLE, LOAD, DATA, CRC, END);
  - default constants MB_DATA_W=8, MB_CRC_W=4, MB_GAP=1, shared with the datapath and receiver.
- Single module, no sub-module. The counter is inline because its terminal count depends on state.
- Elaboration-time checks reject DATA_W, CRC_W or GAP below 1.

## Test plan
- Defaults, Enable pulsed 1 cycle at cycle 0: Load in cycle 1; ShiftEn cycles 2-13; Select=1 in cycles 10-13; CrcEn in cycles 2-9; Done in cycle 14; IDLE in cycle 15.
- Enable held high for 3 frames: Load in cycles 1, 15 and 29; exactly 3 Done pulses; Busy never drops between frames.
- Abort at cycle 6 (mid-DATA): IDLE and Busy=0 in cycle 7; no Done; a new Enable yields a full frame.
- CLR at cycle 11 (mid-CRC): all outputs 0 in cycle 12, BitCnt=0; Enable pulses during CRC and early END are ignored (no extra Load).
- DATA_W=1, CRC_W=1, GAP=3: Enable at cycle 0 gives Load 1, DATA 2, CRC 3, Done 4; END in cycles 4-6; Enable sampled in cycle 6 gives Load in cycle 7.
- Check Abort and CLR in the same cycle (CLR wins, identical result), and Enable high during CLR (no Load until the cycle after CLR deasserts).
